// File: rtl/bip_debug_ctrl.sv
// Debug run controller for the BIP processor.
// Holds the processor in reset until a run is requested, lets it execute until
// it halts or a cycle budget runs out, then streams a status frame: status byte,
// cycle count, pc, acc and a dump of the first DUMP_WORDS data-RAM words.
module bip_debug_ctrl #(
  parameter logic [15:0] MAX_CYCLES = 16'd1000,
  parameter int          DUMP_WORDS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [10:0] pc,
  input  logic [15:0] acc,
  input  logic [15:0] mem_data,
  input  logic        tx_ready,
  output logic        cpu_rst,
  output logic        cpu_en,
  output logic        mem_rd,
  output logic [10:0] mem_addr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [10:0] LAST_IDX  = 11'(DUMP_WORDS - 1);
  localparam logic [7:0]  ST_HALT   = 8'hA5;
  localparam logic [7:0]  ST_TMO    = 8'hE1;
  localparam logic [2:0]  HDR_LAST  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_SEND_HDR,
    S_MEM_RD,
    S_MEM_WAIT,
    S_SEND_MEM,
    S_FIN
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_cnt;
  logic [10:0] r_idx;
  logic [7:0]  r_status;
  logic [10:0] r_pc;
  logic [15:0] r_acc;
  logic [7:0]  r_mem_lo;
  logic [2:0]  r_sel;

  logic        r_cpu_rst;
  logic        r_cpu_en;
  logic        r_mem_rd;
  logic [10:0] r_mem_addr;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_busy;
  logic        r_done;

  logic        w_halt;
  logic        w_tmo;
  logic        w_exit;
  logic        w_xfer;
  logic [10:0] w_next_idx;
  logic [7:0]  w_hdr_next;

  // Run-exit detection, handshake and the header byte that follows the current one.
  always_comb begin
    w_halt     = (r_state == S_RUN) && (r_cnt != 16'd0) && (opcode == 5'b00000);
    w_tmo      = (r_state == S_RUN) && (r_cnt == MAX_CYCLES);
    w_exit     = w_halt || w_tmo;
    w_xfer     = r_tx_valid && tx_ready;
    if (r_state == S_SEND_MEM) begin
      w_next_idx = r_idx + 11'd1;
    end else begin
      w_next_idx = r_idx;
    end
    case (r_sel)
      3'd0:    w_hdr_next = r_cnt[15:8];
      3'd1:    w_hdr_next = r_cnt[7:0];
      3'd2:    w_hdr_next = {5'b00000, r_pc[10:8]};
      3'd3:    w_hdr_next = r_pc[7:0];
      3'd4:    w_hdr_next = r_acc[15:8];
      3'd5:    w_hdr_next = r_acc[7:0];
      default: w_hdr_next = 8'h00;
    endcase
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CLR;
        else       w_next = S_IDLE;
      end
      S_CLR: w_next = S_RUN;
      S_RUN: begin
        if (w_exit) w_next = S_SEND_HDR;
        else        w_next = S_RUN;
      end
      S_SEND_HDR: begin
        if (w_xfer && (r_sel == HDR_LAST)) w_next = S_MEM_RD;
        else                               w_next = S_SEND_HDR;
      end
      S_MEM_RD:   w_next = S_MEM_WAIT;
      S_MEM_WAIT: w_next = S_SEND_MEM;
      S_SEND_MEM: begin
        if (w_xfer && (r_sel == 3'd1)) begin
          if (r_idx == LAST_IDX) w_next = S_FIN;
          else                   w_next = S_MEM_RD;
        end else begin
          w_next = S_SEND_MEM;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Counter, capture registers, byte sequencing and registered control outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt      <= 16'd0;
      r_idx      <= 11'd0;
      r_status   <= 8'h00;
      r_pc       <= 11'd0;
      r_acc      <= 16'd0;
      r_mem_lo   <= 8'h00;
      r_sel      <= 3'd0;
      r_cpu_rst  <= 1'b1;
      r_cpu_en   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= 11'd0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cpu_rst  <= (w_next == S_IDLE) || (w_next == S_CLR);
      r_cpu_en   <= (w_next == S_RUN);
      r_busy     <= (w_next != S_IDLE);
      r_done     <= (w_next == S_FIN);
      r_mem_rd   <= (w_next == S_MEM_RD);
      r_mem_addr <= (w_next == S_MEM_RD) ? w_next_idx : 11'd0;
      case (r_state)
        S_CLR: begin
          r_cnt <= 16'd0;
          r_idx <= 11'd0;
        end
        S_RUN: begin
          if (w_exit) begin
            // Halt takes priority over a simultaneous timeout.
            r_status   <= w_halt ? ST_HALT : ST_TMO;
            r_tx_data  <= w_halt ? ST_HALT : ST_TMO;
            r_tx_valid <= 1'b1;
            r_pc       <= pc;
            r_acc      <= acc;
            r_sel      <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_SEND_HDR: begin
          if (w_xfer) begin
            if (r_sel == HDR_LAST) begin
              r_tx_valid <= 1'b0;
            end else begin
              r_tx_data <= w_hdr_next;
              r_sel     <= r_sel + 3'd1;
            end
          end
        end
        S_MEM_WAIT: begin
          r_tx_data  <= mem_data[15:8];
          r_mem_lo   <= mem_data[7:0];
          r_tx_valid <= 1'b1;
          r_sel      <= 3'd0;
        end
        S_SEND_MEM: begin
          if (w_xfer) begin
            if (r_sel == 3'd0) begin
              r_tx_data <= r_mem_lo;
              r_sel     <= 3'd1;
            end else begin
              r_tx_valid <= 1'b0;
              if (r_idx != LAST_IDX) r_idx <= r_idx + 11'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // cpu_en is gated by the exit condition so the processor does not step on
  // the cycle the halt or timeout is recognised.
  assign cpu_en   = r_cpu_en && !w_exit;
  assign cpu_rst  = r_cpu_rst;
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_bip_debug_ctrl.sv
// Bench for bip_debug_ctrl: a toy processor and data RAM around the DUT, a
// reference that derives each frame from the program and RAM contents, and a
// byte monitor that checks the stream against a queue of expected bytes.
module tb_bip_debug_ctrl;

  localparam int MAXC = 20;
  localparam int DW   = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  opcode;
  logic [10:0] pc;
  logic [15:0] acc;
  logic [15:0] mem_data;
  logic        tx_ready;
  logic        cpu_rst, cpu_en, mem_rd, tx_valid, busy, done;
  logic [10:0] mem_addr;
  logic [7:0]  tx_data;

  logic [4:0]  prog [0:63];
  logic [15:0] ram  [0:2047];
  logic [7:0]  exp_q [$];

  int total = 0;
  int bad   = 0;

  bip_debug_ctrl #(.MAX_CYCLES(16'(MAXC)), .DUMP_WORDS(DW)) dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode), .pc(pc),
    .acc(acc), .mem_data(mem_data), .tx_ready(tx_ready), .cpu_rst(cpu_rst),
    .cpu_en(cpu_en), .mem_rd(mem_rd), .mem_addr(mem_addr), .tx_data(tx_data),
    .tx_valid(tx_valid), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Toy processor: each enabled cycle fetches prog[pc] and adds 3*op+1 to acc.
  always @(posedge clock) begin
    if (cpu_rst) begin
      pc <= 11'd0; acc <= 16'd0; opcode <= 5'd0;
    end else if (cpu_en) begin
      opcode <= prog[pc[5:0]];
      pc     <= pc + 11'd1;
      acc    <= acc + 16'(prog[pc[5:0]]) * 16'd3 + 16'd1;
    end
  end

  // Data RAM with one-cycle read latency.
  always @(posedge clock) begin
    if (mem_rd) mem_data <= ram[mem_addr];
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Byte monitor: pops the scoreboard on every transfer and checks stall stability.
  bit         stalled = 1'b0;
  logic [7:0] stall_data;
  always @(negedge clock) begin
    if (!reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        total++;
        if (!tx_valid || tx_data !== stall_data) begin
          bad++;
          $display("FAIL stall_hold: valid=%0b data=%0h expected valid=1 data=%0h",
                   tx_valid, tx_data, stall_data);
        end
      end
      if (tx_valid && tx_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_byte: got %0h expected no byte", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            bad++;
            $display("FAIL frame_byte: got %0h expected %0h", tx_data, e);
          end
        end
      end
      if (!mem_rd && mem_addr != 11'd0) begin
        total++; bad++;
        $display("FAIL mem_addr_idle: got %0h expected 0", mem_addr);
      end
      stalled    = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  // Reference: the frame follows from the first zero opcode within the budget.
  function automatic int push_expected();
    int          k;
    logic [7:0]  st;
    logic [15:0] a;
    logic [10:0] p;
    k  = MAXC;
    st = 8'hE1;
    for (int i = 1; i <= MAXC; i++) begin
      if (prog[i-1] == 5'd0) begin
        k = i; st = 8'hA5; break;
      end
    end
    a = 16'd0;
    for (int i = 0; i < k; i++) a = a + 16'(prog[i]) * 16'd3 + 16'd1;
    p = 11'(k);
    exp_q.push_back(st);
    exp_q.push_back(8'(k >> 8));
    exp_q.push_back(8'(k & 255));
    exp_q.push_back({5'b00000, p[10:8]});
    exp_q.push_back(p[7:0]);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    for (int w = 0; w < DW; w++) begin
      exp_q.push_back(ram[w][15:8]);
      exp_q.push_back(ram[w][7:0]);
    end
    return k;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_prog(input int halt_at);
    for (int i = 0; i < 64; i++) prog[i] = 5'($urandom_range(1, 31));
    if (halt_at > 0) prog[halt_at-1] = 5'd0;
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    logic r;
    case (mode)
      0:       r = 1'b1;
      1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: r = 1'($urandom_range(0, 1));
    endcase
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_cpu_rst"},  int'(cpu_rst),  1);
    check({tag, "_busy"},     int'(busy),     0);
    check({tag, "_tx_valid"}, int'(tx_valid), 0);
    check({tag, "_mem_rd"},   int'(mem_rd),   0);
    check({tag, "_done"},     int'(done),     0);
  endtask

  // One frame: start, drive tx_ready by mode, pulse stray starts, optionally
  // abort with reset in the middle of the memory dump.
  task automatic run_frame(input int mode, input bit abort);
    int k, en_cnt, vcnt, after_rd;
    bit got_done, gap, seen_rd;
    k = push_expected();
    en_cnt = 0; vcnt = 0; gap = 0; seen_rd = 0; after_rd = 0; got_done = 0;
    tx_ready = ready_for(mode, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      step();
      if (cpu_en) en_cnt++;
      if (tx_valid && !gap) vcnt++;
      if (!tx_valid && vcnt > 0) gap = 1;
      if (done) begin got_done = 1; start = 1'b0; break; end
      if (abort) begin
        if (seen_rd) after_rd++;
        if (mem_rd) seen_rd = 1;
        if (after_rd == 2) begin
          reset = 1'b0;
          tx_ready = 1'b0;
          exp_q.delete();
          step();
          reset = 1'b1;
          start = 1'b0;
          check_idle("abort");
          step();
          check_idle("abort_hold");
          return;
        end
      end
      tx_ready = ready_for(mode, cyc);
      start = ($urandom_range(0, 3) == 0);
    end
    check("done_seen", int'(got_done), 1);
    if (!got_done) begin
      start = 1'b0;
      exp_q.delete();
      return;
    end
    check("busy_at_done", int'(busy), 1);
    check("bytes_left", exp_q.size(), 0);
    check("cpu_en_cycles", en_cnt, k);
    if (mode == 0) check("hdr_back_to_back", vcnt, 7);
    step();
    check_idle("post_done");
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; tx_ready = 1'b0;
    for (int i = 0; i < 2048; i++) ram[i] = 16'(i * 7 + 3);
    set_prog(5);
    repeat (3) step();
    check_idle("reset");
    check("reset_cpu_en",   int'(cpu_en),   0);
    check("reset_mem_addr", int'(mem_addr), 0);
    check("reset_tx_data",  int'(tx_data),  0);
    reset = 1'b1;
    step();
    check_idle("idle");

    ram[0] = 16'h1234; ram[1] = 16'hABCD;
    run_frame(0, 1'b0);            // halt after 5 instructions
    run_frame(1, 1'b0);            // same frame under 1-0-0-1 ready pattern
    set_prog(0);
    run_frame(0, 1'b0);            // timeout
    set_prog(MAXC);
    run_frame(2, 1'b0);            // halt coincides with the budget
    set_prog(MAXC + 1);
    run_frame(2, 1'b0);            // halt just past the budget
    set_prog(1);
    run_frame(0, 1'b0);            // halt on the first counted cycle
    set_prog(7);
    run_frame(0, 1'b1);            // reset mid memory dump
    run_frame(0, 1'b0);            // fresh frame after abort
    for (int n = 0; n < 10; n++) begin
      set_prog(int'($urandom_range(1, MAXC + 4)));
      ram[0] = 16'($urandom); ram[1] = 16'($urandom);
      run_frame(int'($urandom_range(0, 2)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bip_debug_ctrl.md
BIP_DEBUG_CTRL -- requirements
Module: bip_debug_ctrl

Interface
REQ-001 SHALL have parameter MAX_CYCLES, default 16'd1000, meaning run timeout in processor cycles.
REQ-002 SHALL have parameter DUMP_WORDS, default 8, meaning number of data-RAM words dumped from address 0 (range 1..2048).
REQ-003 SHALL have port clock, input, 1, the only clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on posedge clock).
REQ-005 SHALL have port start, input, 1, run request, sampled in IDLE only.
REQ-006 SHALL have port opcode, input, 5, processor's current registered opcode.
REQ-007 SHALL have port pc, input, 11, processor's program counter.
REQ-008 SHALL have port acc, input, 16, processor's accumulator.
REQ-009 SHALL have port mem_data, input, 16, data-RAM read data, valid exactly one cycle after mem_rd.
REQ-010 SHALL have port tx_ready, input, 1, byte sink ready.
REQ-011 SHALL have port cpu_rst, output, 1, active-high processor reset.
REQ-012 SHALL have port cpu_en, output, 1, processor clock enable; one instruction per enabled cycle.
REQ-013 SHALL have port mem_rd, output, 1, data-RAM read strobe (overrides processor RdRam).
REQ-014 SHALL have port mem_addr, output, 11, data-RAM read address.
REQ-015 SHALL have ports tx_data, output, 8, and tx_valid, output, 1, byte stream to sink.
REQ-016 SHALL have ports busy, output, 1 (state != IDLE), and done, output, 1 (one-cycle pulse on frame completion).

Function
REQ-017 SHALL implement FSM states IDLE, CLR, RUN, SEND_HDR, MEM_RD, MEM_WAIT, SEND_MEM, FIN.
REQ-018 IDLE: cpu_rst=1, cpu_en=0; start=1 -> CLR; start ignored in every other state.
REQ-019 CLR: one cycle, cpu_rst=1, 16-bit cycle counter cleared to 0 -> RUN.
REQ-020 RUN: cpu_rst=0, cpu_en=1, counter +1 per cycle.
REQ-021 Halt: in RUN with counter>=1 and opcode==5'b00000 -> SEND_HDR, status byte 8'hA5; cpu_en=0 from that cycle, processor state frozen.
REQ-022 Timeout: counter==MAX_CYCLES in RUN -> SEND_HDR, status 8'hE1; if halt and timeout occur same cycle, halt (8'hA5) wins.
REQ-023 pc and acc SHALL be captured on the RUN exit cycle; counter frozen after exit.
REQ-024 Frame order: status, cnt[15:8], cnt[7:0], {5'b0,pc[10:8]}, pc[7:0], acc[15:8], acc[7:0], then per word MSB byte then LSB byte; total 7+2*DUMP_WORDS bytes.
REQ-025 Handshake: byte transfers on a cycle with tx_valid=1 and tx_ready=1; tx_data and tx_valid SHALL stay stable while tx_valid=1 and tx_ready=0; tx_valid never deasserted without a transfer.
REQ-026 Back-to-back: with tx_ready held 1, header bytes SHALL go out on 7 consecutive cycles.
REQ-027 Memory dump: MEM_RD asserts mem_rd=1 one cycle with mem_addr=word index; MEM_WAIT latches mem_data; SEND_MEM sends 2 bytes; index+1; after index DUMP_WORDS-1 -> FIN.
REQ-028 mem_rd SHALL be 0 and mem_addr 0 outside MEM_RD.
REQ-029 FIN: done=1 for one cycle -> IDLE; cpu_rst returns to 1.
REQ-030 Counter width 16 bits; no wrap possible since MAX_CYCLES<=16'hFFFF stops RUN.

Reset
REQ-031 reset=0 at any posedge SHALL force IDLE regardless of state, including mid-RUN or mid-frame; partial frames are abandoned.
REQ-032 Reset values: cpu_rst=1, cpu_en=0, mem_rd=0, mem_addr=0, tx_valid=0, tx_data=0, busy=0, done=0, counter=0, word index=0.

Verification
REQ-033 Program halting after 5 instructions, tx_ready=1, DUMP_WORDS=2, RAM[0]=16'h1234, RAM[1]=16'hABCD -> bytes A5 00 05 00 pc 00/acc... then 12 34 AB CD, done pulse, busy=0.
REQ-034 Infinite-loop program, MAX_CYCLES=20 -> status E1, cnt bytes 00 14, cpu_en low from cycle 20 onward.
REQ-035 tx_ready toggling 1-0-0-1 pattern -> every byte delivered once, tx_data unchanged during stalls, frame identical to REQ-033.
REQ-036 reset=0 asserted mid-SEND_MEM -> next cycle IDLE, tx_valid=0, cpu_rst=1; new start produces complete fresh frame.
REQ-037 start pulsed during RUN and SEND_HDR -> no effect on count, frame, or state sequence.
REQ-038 Halt opcode coinciding with counter==MAX_CYCLES -> status A5.
